axis_packet_counter: RTL and testbench
======================================

# axis_packet_counter

AXI-Stream pass-through monitor that measures every packet on the link. It counts beats and valid bytes (popcount of tkeep) per packet and pushes one {beats, bytes} record per packet into an internal result FIFO, read out over a valid/ready side port. It sits inline on any AXI-Stream path, e.g. between a DMA and the accelerator, for debug and performance measurement of multi-packet transfers. When the result FIFO is full, it back-pressures the stream at packet boundaries so that no record is lost.

## Interface
- AXIS_BYTES, 4: stream width in bytes; tdata is AXIS_BYTES*8 bits.
- COUNTER_BITS, 32: width of the beat, byte and packet counters.
- RESULT_DEPTH, 4: result FIFO depth; must be a power of two, ≥2.

- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tvalid/tready/tlast  in/out/in  1  upstream handshake.
- s_axis_tdata  in  AXIS_BYTES*8  upstream data.
- s_axis_tkeep  in  AXIS_BYTES  upstream byte enables.
- m_axis_tvalid/tready/tlast  out/in/out  1  downstream handshake.
- m_axis_tdata  out  AXIS_BYTES*8  equals s_axis_tdata.
- m_axis_tkeep  out  AXIS_BYTES  equals s_axis_tkeep.
- r_valid  out  1  result record available.
- r_ready  in  1  result consumer accepts the head record.
- r_beats  out  COUNTER_BITS  beats in the head-record packet.
- r_bytes  out  COUNTER_BITS  valid bytes in the head-record packet.
- packets  out  COUNTER_BITS  total packets completed since reset.
- overflow  out  1  sticky flag: a counter exceeded its range.

## Operation
- Stall term: stall = s_axis_tlast && fifo_full.
  - m_axis_tvalid = s_axis_tvalid && !stall.
  - s_axis_tready = m_axis_tready && !stall.
  - tdata, tkeep and tlast pass through combinationally.
- Beat fire: fire = s_axis_tvalid && s_axis_tready.
- Per fire, kc = popcount(s_axis_tkeep), range 0..AXIS_BYTES.
  - A beat with tkeep = 0 counts as 1 beat and 0 bytes.
- Running accumulators beat_acc and byte_acc are registered.
  - Non-last fire: beat_acc += 1 and byte_acc += kc.
- Last fire:
  - Push record {beat_acc+1, byte_acc+kc}.
  - Clear both accumulators to 0.
  - packets += 1.
- A 1-beat packet therefore yields record {1, kc}.
- Result FIFO:
  - Circular buffer with log2(RESULT_DEPTH)+1-bit read and write pointers.
  - Full when the pointers differ only in the MSB.
  - Empty when the pointers are equal.
  - r_valid = !empty; r_beats and r_bytes show the head entry.
  - Pop on r_valid && r_ready.
- Simultaneous push and pop:
  - Both take effect in the same cycle.
  - fifo_full is the registered state, so a pop in the same cycle does not release the stall. The tlast beat is accepted the following cycle.
- Arithmetic is unsigned, with range limit 2^COUNTER_BITS−1. Behaviour at the limit is set by the macro under Configuration.
- overflow sets on any increment that would exceed the limit. It clears only on areset.
- No state machine beyond the accumulators and FIFO: every packet is counted, with no terminal DONE state.

## Timing
- areset asserted: accumulators = 0, packets = 0, FIFO pointers = 0, overflow = 0. Hence r_valid = 0.
  - m_axis_tvalid and s_axis_tready remain combinational functions of their inputs.
- Reset mid-packet: the partial count is discarded. Beats after reset release are counted as a new packet.
- Pass-through latency is 0 cycles.
- The record is visible on r_valid the cycle after the tlast fire (1-cycle latency). packets updates in that same edge.
- Upstream and downstream follow AXI-Stream rules. Once m_axis_tvalid is high it stays high until m_axis_tready, provided the stall is not asserted. The stall only changes when the FIFO state changes, which requires an r_ready pop.

## Configuration
- AXIS_PACKET_COUNTER_SAT_EN defined:
  - Accumulators and packets saturate at 2^COUNTER_BITS−1 and hold.
  - overflow sets when saturation occurs.
- Undefined:
  - The counters wrap modulo 2^COUNTER_BITS.
  - overflow still sets on the wrap event.

## Test plan
- 3-beat packet, tkeep 1111/1111/0011, r_ready=1 → one record {3, 10}, packets=1, overflow=0.
- Back-to-back packets of 1 beat (tkeep 0001) and 2 beats (1111, 0000) with no idle cycle → records {1,1} then {2,4}, in order.
- r_ready=0, RESULT_DEPTH=4, five 1-beat packets → four records buffered; the 5th tlast beat is held with s_axis_tready=0 and m_axis_tvalid=0. One pop releases it the next cycle, giving a 5th record.
- areset pulsed after beat 2 of a 4-beat packet, then a 2-beat packet of tkeep 1111 → r_valid=0 during reset, then a single record {2, 8}.
- COUNTER_BITS=4, 20-beat packet of tkeep 1111:
  - With AXIS_PACKET_COUNTER_SAT_EN → {15, 15}, overflow=1.
  - Without it → {4, 0} (20 mod 16, 80 mod 16), overflow=1.
- Random m_axis_tready/r_ready toggling over 1000 packets → m-side data identical to s-side, and every record matches the scoreboard.

Source files
------------

// File: rtl/axis_packet_counter.sv
// Inline AXI-Stream monitor. Each packet gets a {beats, bytes} record in a small result FIFO.
// When AXIS_PACKET_COUNTER_SAT_EN is defined the counters saturate; otherwise they wrap.
module axis_packet_counter #(
  parameter int unsigned AXIS_BYTES   = 4,
  parameter int unsigned COUNTER_BITS = 32,
  parameter int unsigned RESULT_DEPTH = 4
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  input  logic [AXIS_BYTES*8-1:0]   s_axis_tdata,
  input  logic [AXIS_BYTES-1:0]     s_axis_tkeep,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [AXIS_BYTES*8-1:0]   m_axis_tdata,
  output logic [AXIS_BYTES-1:0]     m_axis_tkeep,
  output logic                      r_valid,
  input  logic                      r_ready,
  output logic [COUNTER_BITS-1:0]   r_beats,
  output logic [COUNTER_BITS-1:0]   r_bytes,
  output logic [COUNTER_BITS-1:0]   packets,
  output logic                      overflow
);

  localparam int unsigned PTR_W = $clog2(RESULT_DEPTH);
  localparam int unsigned KC_W  = $clog2(AXIS_BYTES + 1);
  localparam int unsigned SUM_W = COUNTER_BITS + 1;

  logic [COUNTER_BITS-1:0] r_beat_acc;
  logic [COUNTER_BITS-1:0] r_byte_acc;
  logic [COUNTER_BITS-1:0] r_packets;
  logic                    r_overflow;
  logic [PTR_W:0]          r_wr_ptr;
  logic [PTR_W:0]          r_rd_ptr;
  logic [COUNTER_BITS-1:0] r_mem_beats [RESULT_DEPTH];
  logic [COUNTER_BITS-1:0] r_mem_bytes [RESULT_DEPTH];

  logic [KC_W-1:0]         w_kc;
  logic [SUM_W-1:0]        w_beat_sum;
  logic [SUM_W-1:0]        w_byte_sum;
  logic [SUM_W-1:0]        w_pkt_sum;
  logic [COUNTER_BITS-1:0] w_beat_nxt;
  logic [COUNTER_BITS-1:0] w_byte_nxt;
  logic [COUNTER_BITS-1:0] w_pkt_nxt;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_stall;
  logic                    w_fire;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_ovf;

  // Hold only the tlast beat while full, so a packet's record always has a slot.
  assign w_full  = (r_wr_ptr ^ r_rd_ptr) == {1'b1, {PTR_W{1'b0}}};
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_stall = s_axis_tlast && w_full;

  assign m_axis_tvalid = s_axis_tvalid && !w_stall;
  assign s_axis_tready = m_axis_tready && !w_stall;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;

  assign w_fire = s_axis_tvalid && s_axis_tready;
  assign w_push = w_fire && s_axis_tlast;
  assign w_pop  = !w_empty && r_ready;

  always_comb begin
    w_kc = '0;
    for (int unsigned i = 0; i < AXIS_BYTES; i++) begin
      w_kc = w_kc + KC_W'(s_axis_tkeep[i]);
    end
  end

  // One extra sum bit flags the increment that leaves the counter range.
  always_comb begin
    w_beat_sum = SUM_W'(r_beat_acc) + SUM_W'(1);
    w_byte_sum = SUM_W'(r_byte_acc) + SUM_W'(w_kc);
    w_pkt_sum  = SUM_W'(r_packets) + SUM_W'(1);
`ifdef AXIS_PACKET_COUNTER_SAT_EN
    w_beat_nxt = w_beat_sum[COUNTER_BITS] ? '1 : w_beat_sum[COUNTER_BITS-1:0];
    w_byte_nxt = w_byte_sum[COUNTER_BITS] ? '1 : w_byte_sum[COUNTER_BITS-1:0];
    w_pkt_nxt  = w_pkt_sum[COUNTER_BITS]  ? '1 : w_pkt_sum[COUNTER_BITS-1:0];
`else
    w_beat_nxt = w_beat_sum[COUNTER_BITS-1:0];
    w_byte_nxt = w_byte_sum[COUNTER_BITS-1:0];
    w_pkt_nxt  = w_pkt_sum[COUNTER_BITS-1:0];
`endif
    w_ovf = w_fire && (w_beat_sum[COUNTER_BITS] || w_byte_sum[COUNTER_BITS] ||
                       (s_axis_tlast && w_pkt_sum[COUNTER_BITS]));
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_beat_acc <= '0;
      r_byte_acc <= '0;
      r_packets  <= '0;
      r_overflow <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if (w_fire) begin
        if (s_axis_tlast) begin
          r_beat_acc <= '0;
          r_byte_acc <= '0;
          r_packets  <= w_pkt_nxt;
        end else begin
          r_beat_acc <= w_beat_nxt;
          r_byte_acc <= w_byte_nxt;
        end
      end
      if (w_ovf) begin
        r_overflow <= 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
      end
    end
  end

  // Record storage needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem_beats[r_wr_ptr[PTR_W-1:0]] <= w_beat_nxt;
      r_mem_bytes[r_wr_ptr[PTR_W-1:0]] <= w_byte_nxt;
    end
  end

  assign r_valid  = !w_empty;
  assign r_beats  = r_mem_beats[r_rd_ptr[PTR_W-1:0]];
  assign r_bytes  = r_mem_bytes[r_rd_ptr[PTR_W-1:0]];
  assign packets  = r_packets;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_axis_packet_counter.sv
// Bench for axis_packet_counter: packet-level scoreboard plus directed literal checks,
// including a narrow-counter instance for the wrap/saturate behaviour.
module tb_axis_packet_counter;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] beats;
    logic [31:0] bytes;
  } rec_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic        s_tvalid, s_tlast, m_tready, r_ready;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tready, m_tvalid, m_tlast, r_valid, overflow;
  logic [31:0] m_tdata, r_beats, r_bytes, packets;
  logic [3:0]  m_tkeep;

  logic        s2_tvalid, s2_tlast, m2_tready, r2_ready;
  logic [3:0]  s2_tkeep;
  logic        s2_tready, m2_tvalid, m2_tlast, r2_valid, overflow2;
  logic [31:0] m2_tdata;
  logic [3:0]  m2_tkeep, r2_beats, r2_bytes, packets2;

  always #5 aclk = ~aclk;

  axis_packet_counter #(.AXIS_BYTES(4), .COUNTER_BITS(32), .RESULT_DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .r_valid(r_valid), .r_ready(r_ready), .r_beats(r_beats), .r_bytes(r_bytes),
    .packets(packets), .overflow(overflow)
  );

  axis_packet_counter #(.AXIS_BYTES(4), .COUNTER_BITS(4), .RESULT_DEPTH(4)) dut_small (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s2_tvalid), .s_axis_tready(s2_tready), .s_axis_tlast(s2_tlast),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s2_tkeep),
    .m_axis_tvalid(m2_tvalid), .m_axis_tready(m2_tready), .m_axis_tlast(m2_tlast),
    .m_axis_tdata(m2_tdata), .m_axis_tkeep(m2_tkeep),
    .r_valid(r2_valid), .r_ready(r2_ready), .r_beats(r2_beats), .r_bytes(r2_bytes),
    .packets(packets2), .overflow(overflow2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packet-level model: records queued by the driver, FIFO occupancy as a queue.
  rec_t        sent[$];
  rec_t        fifo_q[$];
  int unsigned m_pkts;
  bit          mdl_stall, mdl_fire;

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      fifo_q.delete();
      sent.delete();
      m_pkts = 0;
    end else begin
      mdl_stall = s_tlast && (fifo_q.size() == DEPTH);
      mdl_fire  = s_tvalid && m_tready && !mdl_stall;
      if (fifo_q.size() != 0 && r_ready) void'(fifo_q.pop_front());
      if (mdl_fire && s_tlast) begin
        if (sent.size() != 0) fifo_q.push_back(sent.pop_front());
        m_pkts++;
      end
    end
  end

  bit chk_en = 1'b0;
  bit chk_stall;

  always @(negedge aclk) begin
    if (chk_en && !areset) begin
      chk_stall = s_tlast && (fifo_q.size() == DEPTH);
      chk("m_tdata", m_tdata, s_tdata);
      chk("m_tkeep", m_tkeep, s_tkeep);
      chk("m_tlast", m_tlast, s_tlast);
      chk("m_tvalid", m_tvalid, s_tvalid && !chk_stall);
      chk("s_tready", s_tready, m_tready && !chk_stall);
      chk("r_valid", r_valid, fifo_q.size() != 0);
      if (fifo_q.size() != 0) begin
        chk("r_beats", r_beats, fifo_q[0].beats);
        chk("r_bytes", r_bytes, fifo_q[0].bytes);
      end
      chk("packets", packets, m_pkts);
      chk("overflow", overflow, 1'b0);
    end
  end

  bit rnd_en = 1'b0;
  always @(posedge aclk) begin
    if (rnd_en) begin
      #1;
      m_tready = ($urandom_range(0, 9) < 7);
      r_ready  = $urandom_range(0, 1) != 0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit         gaps = 1'b0;
  logic [3:0] kq[$];

  task automatic send_beat(input logic [3:0] keep, input bit last);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    s_tvalid = 1'b1;
    s_tkeep  = keep;
    s_tlast  = last;
    s_tdata  = $urandom;
    while (n < 2000) begin
      @(negedge aclk);
      acc = s_tready;
      @(posedge aclk);
      #1;
      if (acc) break;
      n++;
    end
    chk("beat_accepted", acc, 1'b1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_pkt();
    rec_t r;
    r.beats = 32'(kq.size());
    r.bytes = '0;
    foreach (kq[i]) r.bytes += 32'($countones(kq[i]));
    sent.push_back(r);
    foreach (kq[i]) begin
      send_beat(kq[i], i == kq.size() - 1);
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge aclk);
          #1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  int len;

  initial begin
    areset = 1'b1;
    s_tvalid = 1'b1; s_tlast = 1'b0; s_tkeep = 4'hF; s_tdata = 32'h1234_5678;
    m_tready = 1'b1; r_ready = 1'b0;
    s2_tvalid = 1'b0; s2_tlast = 1'b0; s2_tkeep = 4'h0; m2_tready = 1'b1; r2_ready = 1'b0;

    // Reset state; handshake stays combinational while reset is held
    @(negedge aclk);
    chk("rst_r_valid", r_valid, 1'b0);
    chk("rst_packets", packets, 0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_m_tvalid", m_tvalid, 1'b1);
    chk("rst_s_tready", s_tready, 1'b1);
    s_tvalid = 1'b0;
    step();
    areset = 1'b0;
    chk_en = 1'b1;

    // 3-beat packet
    r_ready = 1'b1;
    kq = '{4'b1111, 4'b1111, 4'b0011};
    send_pkt();
    @(negedge aclk);
    chk("t1_r_valid", r_valid, 1'b1);
    chk("t1_beats", r_beats, 3);
    chk("t1_bytes", r_bytes, 10);
    chk("t1_packets", packets, 1);
    step();
    r_ready = 1'b0;

    // Back-to-back 1-beat and 2-beat packets
    kq = '{4'b0001};
    send_pkt();
    kq = '{4'b1111, 4'b0000};
    send_pkt();
    @(negedge aclk);
    chk("t2_beats0", r_beats, 1);
    chk("t2_bytes0", r_bytes, 1);
    chk("t2_packets", packets, 3);
    step();
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    @(negedge aclk);
    chk("t2_beats1", r_beats, 2);
    chk("t2_bytes1", r_bytes, 4);
    step();
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;

    // FIFO full: the 5th tlast beat is held until one pop
    for (int i = 0; i < 4; i++) begin
      kq = '{4'b0001};
      send_pkt();
    end
    sent.push_back('{beats: 32'd1, bytes: 32'd1});
    s_tvalid = 1'b1; s_tlast = 1'b1; s_tkeep = 4'b0001; s_tdata = $urandom;
    repeat (3) begin
      @(negedge aclk);
      chk("t3_stall_tready", s_tready, 1'b0);
      chk("t3_stall_mvalid", m_tvalid, 1'b0);
      step();
    end
    r_ready = 1'b1;
    @(negedge aclk);
    chk("t3_pop_cycle_tready", s_tready, 1'b0);
    step();
    r_ready = 1'b0;
    @(negedge aclk);
    chk("t3_release_tready", s_tready, 1'b1);
    chk("t3_release_mvalid", m_tvalid, 1'b1);
    step();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    @(negedge aclk);
    chk("t3_packets", packets, 8);
    chk("t3_r_valid", r_valid, 1'b1);
    step();
    r_ready = 1'b1;
    repeat (6) step();
    r_ready = 1'b0;
    @(negedge aclk);
    chk("t3_drained", r_valid, 1'b0);
    step();

    // Reset mid-packet with a record pending
    kq = '{4'b0001};
    send_pkt();
    send_beat(4'b1111, 1'b0);
    send_beat(4'b1111, 1'b0);
    areset = 1'b1;
    @(negedge aclk);
    chk("t4_rst_r_valid", r_valid, 1'b0);
    chk("t4_rst_packets", packets, 0);
    step();
    areset = 1'b0;
    kq = '{4'b1111, 4'b1111};
    send_pkt();
    @(negedge aclk);
    chk("t4_r_valid", r_valid, 1'b1);
    chk("t4_beats", r_beats, 2);
    chk("t4_bytes", r_bytes, 8);
    chk("t4_packets", packets, 1);
    step();
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    @(negedge aclk);
    chk("t4_drained", r_valid, 1'b0);

    // 4-bit counters: 20-beat packet of full tkeep
    chk("t5_ovf_init", overflow2, 1'b0);
    step();
    s2_tvalid = 1'b1;
    s2_tkeep  = 4'hF;
    for (int b = 1; b <= 20; b++) begin
      s2_tlast = (b == 20);
      @(negedge aclk);
      chk("t5_tready", s2_tready, 1'b1);
      if (b == 4) chk("t5_ovf_before_wrap", overflow2, 1'b0);
      if (b == 5) chk("t5_ovf_after_wrap", overflow2, 1'b1);
      step();
    end
    s2_tvalid = 1'b0;
    s2_tlast  = 1'b0;
    @(negedge aclk);
    chk("t5_r_valid", r2_valid, 1'b1);
`ifdef AXIS_PACKET_COUNTER_SAT_EN
    chk("t5_beats", r2_beats, 15);
    chk("t5_bytes", r2_bytes, 15);
`else
    chk("t5_beats", r2_beats, 4);
    chk("t5_bytes", r2_bytes, 0);
`endif
    chk("t5_overflow", overflow2, 1'b1);
    chk("t5_packets", packets2, 1);
    step();

    // Random traffic with random back-pressure on both sides
    gaps = 1'b1;
    rnd_en = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      len = $urandom_range(1, 8);
      kq.delete();
      for (int i = 0; i < len; i++) kq.push_back(4'($urandom_range(0, 15)));
      send_pkt();
    end
    rnd_en = 1'b0;
    @(posedge aclk);
    #2;
    m_tready = 1'b1;
    r_ready  = 1'b1;
    repeat (8) step();
    @(negedge aclk);
    chk("t6_drained", r_valid, 1'b0);
    chk("t6_packets", packets, 1001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
